// File: rtl/alu32_seq.sv
// alu32_seq: command/response sequencer for an external 32-bit ALU (cmd_* in, alu_* out/in, rsp_* out, acc, op_count)
module alu32_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  input  logic        cmd_chain,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [31:0] alu_result,
  input  logic        alu_c,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_v,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_result,
  output logic [3:0]  rsp_flags,
  output logic [31:0] acc,
  output logic [15:0] op_count
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t state, state_nx;
  logic accept;
  always_comb begin
    cmd_ready = state == IDLE || (state == RESP && rsp_ready);
    rsp_valid = state == RESP;
    accept = cmd_valid && cmd_ready;
    state_nx = state == EXEC ? RESP : accept ? EXEC : (state == RESP && !rsp_ready) ? RESP : IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      alu_a <= '0;
      alu_b <= '0;
      alu_op <= '0;
      rsp_result <= '0;
      rsp_flags <= '0;
      acc <= '0;
      op_count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        alu_op <= cmd_op;
        alu_b <= cmd_b;
        alu_a <= cmd_chain ? acc : cmd_a;
      end
      if (state == EXEC) begin
        rsp_result <= alu_result;
        rsp_flags <= {alu_c, alu_n, alu_z, alu_v};
        acc <= alu_result;
      end
      if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_alu32_seq.sv
// tb_alu32_seq: self-checking bench for alu32_seq with a behavioural ALU on the alu_* ports
module tb_alu32_seq;
  logic clk = 0, reset = 1;
  logic cmd_valid = 0, cmd_ready, cmd_chain = 0;
  logic [2:0] cmd_op = 0, alu_op;
  logic [31:0] cmd_a = 0, cmd_b = 0, alu_a, alu_b, alu_result, rsp_result, acc;
  logic alu_c, alu_n, alu_z, alu_v, rsp_valid, rsp_ready = 0;
  logic [3:0] rsp_flags;
  logic [15:0] op_count;
  int n_chk = 0, n_fail = 0;
  logic [31:0] acc_m = 0;
  logic [15:0] cnt_m = 0;

  always #5 clk = ~clk;

  alu32_seq dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_chain(cmd_chain),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_c(alu_c), .alu_n(alu_n), .alu_z(alu_z), .alu_v(alu_v),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .acc(acc), .op_count(op_count)
  );

  // Returns {c,n,z,v,result}; subtraction carry means "no borrow".
  function automatic logic [35:0] alu_f(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    logic [31:0] r;
    logic c, v;
    c = 0;
    v = 0;
    case (op)
      3'd0: r = ~a;
      3'd1: r = ~b;
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ~(a ^ b);
      3'd6: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[31:0];
        c = s[32];
        v = (a[31] == b[31]) && (r[31] != a[31]);
      end
      default: begin
        s = {1'b0, a} + {1'b0, ~b} + 33'd1;
        r = s[31:0];
        c = s[32];
        v = (a[31] != b[31]) && (r[31] != a[31]);
      end
    endcase
    return {c, r[31], r == 32'd0, v, r};
  endfunction

  assign {alu_c, alu_n, alu_z, alu_v, alu_result} = alu_f(alu_op, alu_a, alu_b);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction from IDLE with rsp_ready low; checks latency, backpressure and retire.
  task automatic txn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic chain);
    logic [31:0] aa;
    logic [35:0] e;
    aa = chain ? acc_m : a;
    e = alu_f(op, aa, b);
    cmd_valid = 1;
    cmd_op = op;
    cmd_a = a;
    cmd_b = b;
    cmd_chain = chain;
    chk("txn_cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 0;
    cmd_a = ~a;
    chk("txn_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("txn_alu_a", alu_a, aa);
    chk("txn_alu_b", alu_b, b);
    chk("txn_alu_op", {29'd0, alu_op}, {29'd0, op});
    tick();
    acc_m = e[31:0];
    chk("txn_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    chk("txn_rsp_result", rsp_result, e[31:0]);
    chk("txn_rsp_flags", {28'd0, rsp_flags}, {28'd0, e[35:32]});
    chk("txn_acc", acc, acc_m);
    chk("txn_cmd_ready_bp", {31'd0, cmd_ready}, 32'd0);
    rsp_ready = 1;
    #1;
    chk("txn_cmd_ready_comb", {31'd0, cmd_ready}, 32'd1);
    tick();
    rsp_ready = 0;
    cnt_m++;
    chk("txn_op_count", {16'd0, op_count}, {16'd0, cnt_m});
    chk("txn_idle_rsp_valid", {31'd0, rsp_valid}, 32'd0);
  endtask

  initial begin
    logic [31:0] qa[$], qb[$], qr[$];
    logic [35:0] e;
    logic [2:0] rop;
    logic [31:0] ra, rb;
    tick();
    tick();
    reset = 0;
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", {29'd0, alu_op}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    chk("rst_rsp_flags", {28'd0, rsp_flags}, 32'd0);
    chk("rst_acc", acc, 32'd0);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);

    // Back-to-back: four adds with cmd_valid and rsp_ready held high.
    for (int i = 0; i < 4; i++) begin
      qa.push_back($urandom);
      qb.push_back($urandom);
      qr.push_back(qa[i] + qb[i]);
    end
    rsp_ready = 1;
    cmd_valid = 1;
    cmd_op = 3'd6;
    cmd_chain = 0;
    cmd_a = qa[0];
    cmd_b = qb[0];
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("b2b_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      if (i < 3) begin
        cmd_a = qa[i + 1];
        cmd_b = qb[i + 1];
      end else cmd_valid = 0;
      tick();
      chk("b2b_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("b2b_rsp_result", rsp_result, qr[i]);
      acc_m = qr[i];
      tick();
      cnt_m++;
    end
    rsp_ready = 0;
    chk("b2b_final_idle", {31'd0, rsp_valid}, 32'd0);
    chk("b2b_op_count", {16'd0, op_count}, 32'd4);

    txn(3'd6, 32'hFFFFFFFF, 32'h00000001, 0);
    chk("add_wrap_result", rsp_result, 32'h00000000);
    chk("add_wrap_flags", {28'd0, rsp_flags}, 32'b1010);
    txn(3'd6, 32'h7FFFFFFF, 32'h00000001, 0);
    chk("add_ovf_result", rsp_result, 32'h80000000);
    chk("add_ovf_flags", {28'd0, rsp_flags}, 32'b0101);
    txn(3'd7, 32'h12345678, 32'h80000000, 1);
    chk("sub_chain_result", rsp_result, 32'h00000000);
    chk("sub_chain_flags", {28'd0, rsp_flags}, 32'b1010);
    txn(3'd7, 32'd5, 32'd7, 0);
    chk("sub_neg_result", rsp_result, 32'hFFFFFFFE);
    chk("sub_neg_flags", {28'd0, rsp_flags}, 32'b0100);
    chk("sub_neg_count", {16'd0, op_count}, 32'd8);

    // Backpressure: a second command waits while the response is stalled.
    cmd_valid = 1;
    cmd_op = 3'd6;
    cmd_a = 32'd10;
    cmd_b = 32'd20;
    cmd_chain = 0;
    tick();
    cmd_op = 3'd4;
    cmd_a = 32'hA5A5A5A5;
    cmd_b = 32'h0F0F0F0F;
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      chk("bp_rsp_result", rsp_result, 32'd30);
      chk("bp_alu_a_held", alu_a, 32'd10);
      chk("bp_op_count", {16'd0, op_count}, {16'd0, cnt_m});
      tick();
    end
    rsp_ready = 1;
    #1;
    chk("bp_cmd_ready_release", {31'd0, cmd_ready}, 32'd1);
    tick();
    cmd_valid = 0;
    rsp_ready = 0;
    cnt_m++;
    chk("bp_second_alu_a", alu_a, 32'hA5A5A5A5);
    chk("bp_second_alu_op", {29'd0, alu_op}, 32'd4);
    chk("bp_op_count_retire", {16'd0, op_count}, {16'd0, cnt_m});
    tick();
    chk("bp_second_result", rsp_result, 32'hAAAAAAAA);
    chk("bp_second_flags", {28'd0, rsp_flags}, 32'b0100);
    acc_m = 32'hAAAAAAAA;
    rsp_ready = 1;
    tick();
    rsp_ready = 0;
    cnt_m++;
    chk("bp_final_count", {16'd0, op_count}, {16'd0, cnt_m});

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = (i % 4 == 0) ? ra : $urandom;
      txn(rop, ra, rb, 1'($urandom_range(0, 1)));
    end

    // Reset while a command is executing discards it.
    cmd_valid = 1;
    cmd_op = 3'd6;
    cmd_a = 32'd100;
    cmd_b = 32'd200;
    tick();
    cmd_valid = 0;
    reset = 1;
    tick();
    reset = 0;
    acc_m = 0;
    cnt_m = 0;
    chk("rexec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rexec_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rexec_acc", acc, 32'd0);
    chk("rexec_op_count", {16'd0, op_count}, 32'd0);
    chk("rexec_alu_a", alu_a, 32'd0);
    tick();
    chk("rexec_stays_idle", {31'd0, rsp_valid}, 32'd0);
    txn(3'd6, 32'd2, 32'd3, 0);
    chk("rexec_add_result", rsp_result, 32'd5);
    chk("rexec_add_count", {16'd0, op_count}, 32'd1);
    e = alu_f(3'd1, 32'd0, 32'd0);
    txn(3'd1, 32'd0, 32'd0, 1);
    chk("not_b_result", rsp_result, e[31:0]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
